// File: rtl/norm32.sv
// Multi-cycle leading-bit counter/normalizer for CLZ, CLO and NORM.
// A 5-step binary search (16/8/4/2/1) finds the shift that left-justifies T.
module norm32 #(
  parameter logic [4:0] CLZ  = 5'h10,
  parameter logic [4:0] CLO  = 5'h11,
  parameter logic [4:0] NORM = 5'h12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] T,
  input  logic [4:0]  ntype,
  output logic        busy,
  output logic        done,
  output logic [31:0] Y_lo,
  output logic [31:0] Y_hi,
  output logic        C,
  output logic        V,
  output logic        N,
  output logic        Z
);

  typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_e;

  state_e      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [31:0] w_q, w_d;
  logic [31:0] t_q, t_d;
  logic        tb_q, tb_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [5:0]  ylo_q, ylo_d;
  logic [31:0] yhi_q, yhi_d;
  logic        c_q, c_d, n_q, n_d, z_q, z_d;

  logic        load, fast, match;
  logic [5:0]  width, res_cnt;
  logic [31:0] res_val, res_shift;

  // Top w bits of the working register all equal the target bit.
  always_comb begin
    match = 1'b0;
    width = 6'd16 >> k_q;
    case (k_q)
      3'd0:    match = (w_q[31:16] == {16{tb_q}});
      3'd1:    match = (w_q[31:24] == {8{tb_q}});
      3'd2:    match = (w_q[31:28] == {4{tb_q}});
      3'd3:    match = (w_q[31:30] == {2{tb_q}});
      default: match = (w_q[31] == tb_q);
    endcase
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    w_d     = w_q;
    t_d     = t_q;
    tb_d    = tb_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    fast    = 1'b0;
    res_cnt = cnt_q;
    res_val = t_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          t_d     = T;
          cnt_d   = '0;
          k_d     = '0;
          w_d     = T;
          tb_d    = 1'b0;
          res_val = T;
          res_cnt = 6'd32;
          if (ntype == CLZ) begin
            fast = (T == '0);
          end else if (ntype == CLO) begin
            tb_d = 1'b1;
            fast = (T == '1);
          end else if (ntype == NORM) begin
            // Inverted sentinel in bit 0 bounds the run at 31 redundant bits.
            w_d  = {T[30:0], ~T[31]};
            tb_d = T[31];
          end else begin
            fast    = 1'b1;
            res_cnt = '0;
          end
          if (fast) begin
            load    = 1'b1;
            state_d = DONE;
          end else begin
            state_d = SEARCH;
          end
        end
      end
      SEARCH: begin
        if (match) begin
          w_d   = w_q << width;
          cnt_d = cnt_q + width;
        end
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          load    = 1'b1;
          res_cnt = cnt_d;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    res_shift = res_val << res_cnt;
    ylo_d = ylo_q;
    yhi_d = yhi_q;
    c_d   = c_q;
    n_d   = n_q;
    z_d   = z_q;
    if (load) begin
      ylo_d = res_cnt;
      yhi_d = res_shift;
      n_d   = res_shift[31];
      z_d   = (res_cnt == 6'd0);
      c_d   = (res_cnt == 6'd32);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      k_q     <= '0;
      w_q     <= '0;
      t_q     <= '0;
      tb_q    <= 1'b0;
      cnt_q   <= '0;
      ylo_q   <= '0;
      yhi_q   <= '0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      w_q     <= w_d;
      t_q     <= t_d;
      tb_q    <= tb_d;
      cnt_q   <= cnt_d;
      ylo_q   <= ylo_d;
      yhi_q   <= yhi_d;
      c_q     <= c_d;
      n_q     <= n_d;
      z_q     <= z_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);
  assign Y_lo = {26'b0, ylo_q};
  assign Y_hi = yhi_q;
  assign C    = c_q;
  assign V    = 1'b0;
  assign N    = n_q;
  assign Z    = z_q;

endmodule

// File: tb/tb_norm32.sv
// Directed + random bench for norm32 with a scoreboard queue of expected results.
module tb_norm32;

  localparam logic [4:0] OP_CLZ  = 5'h10;
  localparam logic [4:0] OP_CLO  = 5'h11;
  localparam logic [4:0] OP_NORM = 5'h12;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] T;
  logic [4:0]  ntype;
  logic        busy, done, C, V, N, Z;
  logic [31:0] Y_lo, Y_hi;

  int n_assert = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  fl;
    int          lat;
  } exp_t;

  exp_t sb[$];

  norm32 dut (
    .clk(clk), .reset(reset), .start(start), .T(T), .ntype(ntype),
    .busy(busy), .done(done), .Y_lo(Y_lo), .Y_hi(Y_hi),
    .C(C), .V(V), .N(N), .Z(Z)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Bit-serial reference: scan from the MSB for the run of the target bit.
  function automatic exp_t model(input logic [4:0] op, input logic [31:0] t);
    exp_t e;
    int   c;
    logic b;
    logic stop;
    logic legal;
    legal = 1'b1;
    b     = 1'b0;
    case (op)
      OP_CLZ:  b = 1'b0;
      OP_CLO:  b = 1'b1;
      OP_NORM: b = t[31];
      default: legal = 1'b0;
    endcase
    c    = 0;
    stop = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (!stop && t[i] == b) c++;
      else stop = 1'b1;
    end
    if (op == OP_NORM) c = c - 1;
    if (!legal) c = 0;
    e.lo  = c;
    e.hi  = (c == 32) ? 32'h0 : (t << c);
    e.fl  = {(c == 32), 1'b0, e.hi[31], (c == 0)};
    e.lat = (!legal || c == 32) ? 1 : 6;
    return e;
  endfunction

  // Called #1 after the accepting edge; counts edges (accept = 1) until done.
  task automatic wait_done(input int first, output int lat);
    lat = first;
    while (done !== 1'b1 && lat < 20) begin
      chk("busy_while_running", {31'b0, busy}, 32'd1);
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_pop(input string tag, input int lat);
    exp_t e;
    chk({tag, "_sb_size"}, sb.size(), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_Y_lo"}, Y_lo, e.lo);
      chk({tag, "_Y_hi"}, Y_hi, e.hi);
      chk({tag, "_CVNZ"}, {28'b0, C, V, N, Z}, {28'b0, e.fl});
      chk({tag, "_latency"}, lat, e.lat);
      chk({tag, "_busy_in_done"}, {31'b0, busy}, 32'd1);
    end
  endtask

  task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] t);
    int lat;
    sb.push_back(model(op, t));
    @(negedge clk);
    start = 1'b1; ntype = op; T = t;
    @(posedge clk); #1;
    start = 1'b0; T = $urandom; ntype = 5'($urandom);
    wait_done(1, lat);
    check_pop(tag, lat);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, {31'b0, done}, 32'd0);
    chk({tag, "_idle_busy"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    int seen;
    logic [4:0] rop;
    reset = 1'b0; start = 1'b0; T = '0; ntype = '0;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_Y_lo", Y_lo, 32'd0);
    chk("rst_Y_hi", Y_hi, 32'd0);
    chk("rst_CVNZ", {28'b0, C, V, N, Z}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_op("clz_1000",  OP_CLZ,  32'h0000_1000);
    run_op("clz_zero",  OP_CLZ,  32'h0000_0000);
    run_op("clo_ones",  OP_CLO,  32'hFFFF_FFFF);
    run_op("clo_fff0",  OP_CLO,  32'hFFF0_0000);
    run_op("clz_msb",   OP_CLZ,  32'h8000_0000);
    run_op("norm_8000", OP_NORM, 32'hFFFF_8000);
    run_op("norm_one",  OP_NORM, 32'h0000_0001);
    run_op("norm_zero", OP_NORM, 32'h0000_0000);
    run_op("norm_ones", OP_NORM, 32'hFFFF_FFFF);
    run_op("illegal",   5'h1F,   32'h1234_5678);
    run_op("clz_lsb",   OP_CLZ,  32'h0000_0001);

    // start held high throughout; operand changes mid-search.
    sb.push_back(model(OP_CLZ, 32'h00FF_0000));
    @(negedge clk);
    start = 1'b1; ntype = OP_CLZ; T = 32'h00FF_0000;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    T = 32'h0000_0001;
    wait_done(3, lat);
    check_pop("hold_start", lat);
    @(posedge clk); #1;
    chk("hold_back_idle", {31'b0, busy}, 32'd0);
    sb.push_back(model(OP_CLZ, 32'h0000_0001));
    @(posedge clk); #1;
    chk("hold_reaccept", {31'b0, busy}, 32'd1);
    start = 1'b0;
    wait_done(1, lat);
    check_pop("hold_second", lat);
    @(posedge clk); #1;

    for (int i = 0; i < 8; i++) begin
      rop = (i % 3 == 0) ? OP_CLZ : (i % 3 == 1) ? OP_CLO : OP_NORM;
      run_op("random", rop, $urandom >> $urandom_range(0, 31));
    end

    // Asynchronous reset at SEARCH k = 2.
    run_op("pre_reset", OP_CLO, 32'hFFFF_FFF0);
    @(negedge clk);
    start = 1'b1; ntype = OP_CLZ; T = 32'h0000_1000;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", {31'b0, busy}, 32'd0);
    chk("arst_done", {31'b0, done}, 32'd0);
    chk("arst_Y_lo", Y_lo, 32'd0);
    chk("arst_Y_hi", Y_hi, 32'd0);
    chk("arst_CVNZ", {28'b0, C, V, N, Z}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    chk("arst_no_done", seen, 32'd0);
    run_op("post_reset", OP_NORM, 32'h0003_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/norm32.md
Name: norm32

Overview:
- Multi-cycle leading-bit counter and normalizer. It is the inverse companion of the barrel shifter: given a 32-bit value, it finds the left-shift amount that left-justifies the value, and produces that amount plus the normalized value.
- Sits beside the shifter in the ALU/MPY/DIV group of the MIPS datapath and serves CLZ, CLO and NORM (count redundant sign bits).
- Uses a start/busy/done handshake so it can occupy the execute stage for several cycles.

Parameters:
- CLZ, 5'h10, ntype code: count leading zeros
- CLO, 5'h11, ntype code: count leading ones
- NORM, 5'h12, ntype code: count redundant sign bits (leading copies of T[31], minus 1)

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- start  input  1  request; sampled only in IDLE
- T  input  32  operand; captured on accept
- ntype  input  5  operation code; captured on accept
- busy  output  1  high from the cycle after accept until DONE exits
- done  output  1  one-cycle completion pulse
- Y_lo  output  32  count, zero-extended (6 significant bits, range 0..32)
- Y_hi  output  32  normalized value, T << count, zero fill (0 when count = 32)
- C, V, N, Z  output  1 each  status flags

Behaviour:
- Reset (reset = 0, asynchronous, takes effect immediately):
  - state = IDLE; busy = done = 0; Y_lo = Y_hi = 0; C = V = N = Z = 0.
  - Reset during SEARCH or DONE aborts the operation; no done pulse is produced.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - On a clk edge with start = 1: latch T and ntype, then set up the working register W, the target bit tb, and count cnt = 0.
    - CLZ: W = T, tb = 0.
    - CLO: W = T, tb = 1.
    - NORM: W = {T[30:0], ~T[31]}, tb = T[31]. The sentinel bit guarantees a stop at or before 31.
  - Fast path to DONE, skipping SEARCH:
    - CLZ with T = 0, or CLO with T = 0xFFFF_FFFF: count = 32.
    - Illegal ntype: count = 0, Y_hi = T.
  - Otherwise go to SEARCH with step index k = 0.
  - start = 0 in IDLE: no change.
- SEARCH, exactly 5 cycles, k = 0..4, width w = 16, 8, 4, 2, 1:
  - If W[31:32-w] are all equal to tb: W <= W << w and cnt <= cnt + w.
  - After k = 4, go to DONE.
  - cnt never exceeds 31 in SEARCH.
- DONE (1 cycle): done = 1; outputs are updated on entry to DONE:
  - Y_lo = {26'b0, cnt}, where cnt is 32 on the fast path.
  - Y_hi = latched T << cnt (32 bits), 0 if cnt = 32.
  - Flags:
    - N = Y_hi[31].
    - Z = (Y_lo == 0).
    - C = (Y_lo == 32).
    - V = 0.
  - Illegal ntype: Y_lo = 0, Y_hi = T, N = T[31], Z = 1, C = 0, V = 0.
  - The next edge always returns to IDLE.
- busy: 1 in SEARCH and DONE; 0 in IDLE.
- start while busy = 1 (SEARCH or DONE) is ignored. A new request requires start = 1 in IDLE.
- Y_lo, Y_hi and the flags hold their last values until the next DONE entry. They are not cleared on accept.
- Latency from the accepting edge to done = 1:
  - normal: 6 edges (5 SEARCH + entry to DONE);
  - fast path: 1 edge.
- Back-to-back throughput: one operation per 7 cycles (normal) or 2 cycles (fast path).
- T and ntype may change after the accepting edge without affecting the result.

Test Plan:
- CLZ, T = 0x0000_1000, start for 1 cycle -> done pulses 6 edges later; Y_lo = 19, Y_hi = 0x8000_0000, N = 1, Z = 0, C = 0, V = 0; busy high for 6 cycles.
- CLZ, T = 0x0000_0000 -> done 1 edge after accept; Y_lo = 32, Y_hi = 0, C = 1, Z = 0, N = 0. Also CLO, T = 0xFFFF_FFFF -> Y_lo = 32, C = 1.
- CLO, T = 0xFFF0_0000 -> Y_lo = 12, Y_hi = 0x0000_0000, Z = 0. Also CLZ, T = 0x8000_0000 -> Y_lo = 0, Y_hi = 0x8000_0000, Z = 1, N = 1.
- NORM cases:
  - T = 0xFFFF_8000 -> Y_lo = 16, Y_hi = 0x8000_0000.
  - T = 0x0000_0001 -> Y_lo = 30, Y_hi = 0x4000_0000.
  - T = 0x0000_0000 -> Y_lo = 31, Y_hi = 0.
  - T = 0xFFFF_FFFF -> Y_lo = 31, Y_hi = 0x8000_0000.
- Handshake:
  - Hold start high across an entire CLZ (T = 0x00FF_0000) while changing T to 0x1 mid-search -> result is Y_lo = 8, taken from the captured operand.
  - A second accept occurs only on the first edge back in IDLE.
  - Illegal ntype 5'h1F, T = 0x1234_5678 -> fast path; Y_lo = 0, Y_hi = 0x1234_5678, Z = 1.
- Reset: assert reset = 0 at SEARCH k = 2 -> busy, done, Y_lo, Y_hi and flags go to 0 immediately without waiting for clk. After release, no done pulse occurs until a new start.
